// File: rtl/alu.sv
// Registered 32-bit ALU: add/sub/mul/div, logic, shifts and rotates into a 64-bit result.
// Latency: 1 cycle; every operation, including MUL and DIV, completes in a single clock.
// Backpressure: none; a new result is captured on every rising edge with no handshake.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RA,
  input  logic [31:0] RB,
  input  logic [4:0]  opcode,
  output logic [63:0] RZ
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_NEG  = 5'b01101;

  logic [4:0]         shamt;
  logic [5:0]         shinv;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] quo;
  logic signed [31:0] rem;
  logic [63:0]        prod;
  logic [63:0]        result;

  assign shamt = RB[4:0];
  // Shifting by the full width yields zero, so rotate-by-0 collapses to RA alone.
  assign shinv = 6'd32 - {1'b0, shamt};
  assign sa    = RA;
  assign sb    = RB;

  // Sign-extend both operands to 64 bits so the low 64 bits of the product are the signed product.
  assign prod = {{32{RA[31]}}, RA} * {{32{RB[31]}}, RB};

  // Signed divide; the zero-divisor and most-negative/-1 cases are overridden explicitly.
  always_comb begin
    quo = sa / sb;
    rem = sa % sb;
    if (RB == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = sa;
    end else if (RA == 32'h8000_0000 && RB == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end
  end

  // Opcode decode; 32-bit operations leave the upper half zero.
  always_comb begin
    result = 64'd0;
    case (opcode)
      OP_ADD:  result[31:0] = RA + RB;
      OP_SUB:  result[31:0] = RA - RB;
      OP_MUL:  result       = prod;
      OP_DIV:  result       = {rem, quo};
      OP_AND:  result[31:0] = RA & RB;
      OP_OR:   result[31:0] = RA | RB;
      OP_SHL:  result[31:0] = RA << shamt;
      OP_SHR:  result[31:0] = RA >> shamt;
      OP_SHRA: result[31:0] = sa >>> shamt;
      OP_ROL:  result[31:0] = (RA << shamt) | (RA >> shinv);
      OP_ROR:  result[31:0] = (RA >> shamt) | (RA << shinv);
      OP_XOR:  result[31:0] = RA ^ RB;
      OP_NOT:  result[31:0] = ~RA;
      OP_NEG:  result[31:0] = 32'd0 - RA;
      default: result       = 64'd0;
    endcase
  end

  // Result register; reset clears it immediately and holds it at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RZ <= 64'd0;
    end else begin
      RZ <= result;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized checks against a reference model.
// Latency: checks sample RZ 1 time unit after the capturing rising edge.
// Backpressure: not applicable; inputs change on the falling edge every cycle.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] RA;
  logic [31:0] RB;
  logic [4:0]  opcode;
  logic [63:0] RZ;

  int errors;
  int checks;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .RA     (RA),
    .RB     (RB),
    .opcode (opcode),
    .RZ     (RZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed from the operation definitions with plain arithmetic and bit loops.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo;
    logic [31:0] hi;
    longint      la;
    longint      lb;
    longint      ma;
    longint      mb;
    longint      q;
    longint      r;
    longint      p;
    int          s;
    lo = 32'd0;
    hi = 32'd0;
    la = longint'(signed'(a));
    lb = longint'(signed'(b));
    s  = int'(b[4:0]);
    case (op)
      5'd0:  begin p = la + lb; lo = p[31:0]; end
      5'd1:  begin p = la - lb; lo = p[31:0]; end
      5'd2:  begin p = la * lb; return p; end
      5'd3: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          ma = (la < 0) ? -la : la;
          mb = (lb < 0) ? -lb : lb;
          q  = ma / mb;
          r  = ma - q * mb;
          if ((la < 0) != (lb < 0)) q = -q;
          if (la < 0) r = -r;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      5'd4:  lo = a & b;
      5'd5:  lo = a | b;
      5'd6:  begin lo = a; repeat (s) lo = {lo[30:0], 1'b0}; end
      5'd7:  begin lo = a; repeat (s) lo = {1'b0, lo[31:1]}; end
      5'd8:  begin lo = a; repeat (s) lo = {lo[31], lo[31:1]}; end
      5'd9:  begin lo = a; repeat (s) lo = {lo[30:0], lo[31]}; end
      5'd10: begin lo = a; repeat (s) lo = {lo[0], lo[31:1]}; end
      5'd11: lo = a ^ b;
      5'd12: lo = ~a;
      5'd13: begin p = -la; lo = p[31:0]; end
      default: begin lo = 32'd0; hi = 32'd0; end
    endcase
    return {hi, lo};
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    opcode = 5'd0;
    RA     = 32'd3;
    RB     = 32'd4;
    #1;
    checks++;
    if (RZ !== 64'd0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", RZ, 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (RZ !== 64'd7) begin
      errors++;
      $display("FAIL reset_prefill: got %h expected %h", RZ, 64'd7);
    end
    // Assert reset mid-cycle; RZ must clear without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (RZ !== 64'd0) begin
      errors++;
      $display("FAIL reset_async_clear: got %h expected %h", RZ, 64'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (RZ !== 64'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", RZ, 64'd0);
    end
    @(negedge clk);
    opcode = 5'd0;
    RA     = 32'd8;
    RB     = 32'd8;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (RZ !== 64'h0000_0000_0000_0010) begin
      errors++;
      $display("FAIL reset_release_add: got %h expected %h", RZ, 64'h10);
    end
  endtask

  task automatic test_directed();
    logic [4:0]  ops  [24];
    logic [31:0] as   [24];
    logic [31:0] bs   [24];
    logic [63:0] exps [24];
    ops[0]  = 5'd2;  as[0]  = 32'd16;         bs[0]  = 32'd8;          exps[0]  = 64'h0000_0000_0000_0080;
    ops[1]  = 5'd2;  as[1]  = 32'hFFFF_FFF8;  bs[1]  = 32'd8;          exps[1]  = 64'hFFFF_FFFF_FFFF_FFC0;
    ops[2]  = 5'd2;  as[2]  = 32'd8;          bs[2]  = 32'hFFFF_FFF8;  exps[2]  = 64'hFFFF_FFFF_FFFF_FFC0;
    ops[3]  = 5'd2;  as[3]  = 32'hFFFF_FFF8;  bs[3]  = 32'hFFFF_FFF8;  exps[3]  = 64'h0000_0000_0000_0040;
    ops[4]  = 5'd3;  as[4]  = 32'd36;         bs[4]  = 32'd6;          exps[4]  = 64'h0000_0000_0000_0006;
    ops[5]  = 5'd3;  as[5]  = 32'hFFFF_FFF9;  bs[5]  = 32'd2;          exps[5]  = 64'hFFFF_FFFF_FFFF_FFFD;
    ops[6]  = 5'd3;  as[6]  = 32'd5;          bs[6]  = 32'd0;          exps[6]  = 64'h0000_0005_FFFF_FFFF;
    ops[7]  = 5'd3;  as[7]  = 32'h8000_0000;  bs[7]  = 32'hFFFF_FFFF;  exps[7]  = 64'h0000_0000_8000_0000;
    ops[8]  = 5'd6;  as[8]  = 32'd6;          bs[8]  = 32'd1;          exps[8]  = 64'h0000_0000_0000_000C;
    ops[9]  = 5'd8;  as[9]  = 32'h8000_0000;  bs[9]  = 32'd4;          exps[9]  = 64'h0000_0000_F800_0000;
    ops[10] = 5'd7;  as[10] = 32'h8000_0000;  bs[10] = 32'd4;          exps[10] = 64'h0000_0000_0800_0000;
    ops[11] = 5'd10; as[11] = 32'h0000_0001;  bs[11] = 32'd1;          exps[11] = 64'h0000_0000_8000_0000;
    ops[12] = 5'd13; as[12] = 32'hFFFF_FFF8;  bs[12] = 32'hFFFF_FFF8;  exps[12] = 64'h0000_0000_0000_0008;
    ops[13] = 5'd12; as[13] = 32'd0;          bs[13] = 32'h1234_5678;  exps[13] = 64'h0000_0000_FFFF_FFFF;
    ops[14] = 5'd4;  as[14] = 32'hF0F0_F0F0;  bs[14] = 32'hFF00_FF00;  exps[14] = 64'h0000_0000_F000_F000;
    ops[15] = 5'd0;  as[15] = 32'hFFFF_FFFF;  bs[15] = 32'd1;          exps[15] = 64'h0000_0000_0000_0000;
    ops[16] = 5'd1;  as[16] = 32'd0;          bs[16] = 32'd1;          exps[16] = 64'h0000_0000_FFFF_FFFF;
    ops[17] = 5'd31; as[17] = 32'hDEAD_BEEF;  bs[17] = 32'h1234_5678;  exps[17] = 64'h0000_0000_0000_0000;
    ops[18] = 5'd13; as[18] = 32'h8000_0000;  bs[18] = 32'd0;          exps[18] = 64'h0000_0000_8000_0000;
    ops[19] = 5'd9;  as[19] = 32'h8000_0001;  bs[19] = 32'd1;          exps[19] = 64'h0000_0000_0000_0003;
    ops[20] = 5'd9;  as[20] = 32'hA5A5_1234;  bs[20] = 32'hFFFF_FFE0;  exps[20] = 64'h0000_0000_A5A5_1234;
    ops[21] = 5'd8;  as[21] = 32'h8123_4567;  bs[21] = 32'd0;          exps[21] = 64'h0000_0000_8123_4567;
    ops[22] = 5'd5;  as[22] = 32'hF000_0000;  bs[22] = 32'h0000_000F;  exps[22] = 64'h0000_0000_F000_000F;
    ops[23] = 5'd11; as[23] = 32'hFFFF_0000;  bs[23] = 32'h0F0F_0F0F;  exps[23] = 64'h0000_0000_F0F0_0F0F;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      opcode = ops[i];
      RA     = as[i];
      RB     = bs[i];
      @(posedge clk);
      #1;
      checks++;
      if (RZ !== exps[i]) begin
        errors++;
        $display("FAIL directed_%0d op=%b a=%h b=%h: got %h expected %h", i, ops[i], as[i], bs[i], RZ, exps[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    opcode = 5'd0;
    RA     = 32'd1;
    RB     = 32'd2;
    @(posedge clk);
    #1;
    opcode = 5'd1;
    RA     = 32'd100;
    RB     = 32'd1;
    #2;
    checks++;
    if (RZ !== 64'd3) begin
      errors++;
      $display("FAIL hold_between_edges: got %h expected %h", RZ, 64'd3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (RZ !== 64'd99) begin
      errors++;
      $display("FAIL hold_next_edge: got %h expected %h", RZ, 64'd99);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      exp = ref_alu(op, a, b);
      @(negedge clk);
      opcode = op;
      RA     = a;
      RB     = b;
      @(posedge clk);
      #1;
      checks++;
      if (RZ !== exp) begin
        errors++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got %h expected %h", i, op, a, b, RZ, exp);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit arithmetic/logic unit for the datapath. Combines operands RA and RB according to a 5-bit opcode and captures the result in a 64-bit register RZ on every rising clock edge. The 64-bit width holds the full signed product for multiply, and the quotient and remainder pair for divide. Sits between the RA/RB operand latches and the Z register path.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears RZ.
- RA  input  32  operand A; two's complement where signed.
- RB  input  32  operand B; two's complement where signed; RB[4:0] is the shift/rotate amount.
- opcode  input  5  operation select.
- RZ  output  64  registered result.

## Operation
- Result is computed combinationally from RA, RB and opcode. It is registered into RZ on each rising clk edge; there is no enable.
- Unless stated otherwise, an operation writes its 32-bit result to RZ[31:0] and forces RZ[63:32] to 0.
- Opcode map:
  - 00000 ADD: RA + RB, modulo 2^32.
  - 00001 SUB: RA − RB, modulo 2^32.
  - 00010 MUL: signed 32×32 multiply; the full 64-bit signed product goes to RZ[63:0].
  - 00011 DIV: signed divide. RZ[31:0] = quotient, truncated toward zero. RZ[63:32] = remainder, with the sign of RA.
  - 00100 AND: RA & RB.
  - 00101 OR: RA | RB.
  - 00110 SHL: RA << RB[4:0], zero fill.
  - 00111 SHR: RA >> RB[4:0], zero fill.
  - 01000 SHRA: RA >> RB[4:0], sign fill.
  - 01001 ROL: RA rotated left by RB[4:0].
  - 01010 ROR: RA rotated right by RB[4:0].
  - 01011 XOR: RA ^ RB.
  - 01100 NOT: ~RA; RB ignored.
  - 01101 NEG: −RA, two's complement; RB ignored.
  - 01110–11111: RZ = 0.
- Carry and overflow are not reported; ADD/SUB/NEG wrap silently.
- DIV boundary cases:
  - RB = 0: quotient = 0xFFFFFFFF, remainder = RA.
  - RA = 0x80000000 with RB = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- NEG of 0x80000000 gives 0x80000000.
- Shift amount 0 passes RA through unchanged for all shifts and rotates.

## Timing
- Latency is 1 cycle. Inputs present before rising edge N appear on RZ immediately after edge N and hold until the next edge.
- All operations, including MUL and DIV, complete in a single cycle. There is no handshake, busy or valid signal.
- reset asserted: RZ goes to 0 immediately, without waiting for clk, and stays 0 while reset is high.
- reset deasserted: the first rising edge captures the current result.
- Input changes between edges have no effect on RZ until the next edge.

## Test plan
- Reset: assert reset mid-cycle with RZ nonzero → RZ = 0 before the next edge. Then release reset with ADD, RA=8, RB=8 → after the next edge RZ = 0x0000000000000010.
- MUL sign cases, one edge each:
  - 16×8 → RZ = 0x0000000000000080.
  - −8×8 → RZ = 0xFFFFFFFFFFFFFFC0.
  - 8×−8 → RZ = 0xFFFFFFFFFFFFFFC0.
  - −8×−8 → RZ = 0x0000000000000040.
- DIV:
  - 36/6 → RZ = 0x0000000000000006.
  - −7/2 → RZ[31:0] = 0xFFFFFFFD, RZ[63:32] = 0xFFFFFFFF.
  - 5/0 → RZ[31:0] = 0xFFFFFFFF, RZ[63:32] = 5.
- Shifts:
  - SHL 6 by 1 → 0x000000000000000C.
  - SHRA 0x80000000 by 4 → RZ[31:0] = 0xF8000000.
  - SHR 0x80000000 by 4 → 0x08000000.
  - ROR 0x00000001 by 1 → 0x80000000.
- Unary and logic:
  - NEG −8 → RZ = 0x0000000000000008 (opcode 01101, RA=−8, RB=−8).
  - NOT 0 → 0x00000000FFFFFFFF.
  - AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000.
- Wrap and unused opcodes:
  - ADD 0xFFFFFFFF + 1 → RZ = 0.
  - SUB 0 − 1 → RZ = 0x00000000FFFFFFFF.
  - Opcode 11111 → RZ = 0.
